// File: rtl/vend_countdown.sv
// -----------------------------------------------------------------------------
// vend_countdown
//
// Transaction countdown timer for the vending machine. The slow square wave
// from the tick divider arrives as a plain clk-domain signal; its rising edges
// are detected here. A prescaler groups TICKS_PER_UNIT rises into one unit, and
// each unit decrements the loaded count (0..99). Start, pause and cancel
// control the countdown. Outputs drive the display (binary and BCD), a
// low-time warning and a single-cycle expiry pulse to the vending controller.
//
// Parameters
//   TICKS_PER_UNIT : tick rising edges per one-unit decrement (>= 1)
//   WARN_SECS      : warn while running and 0 < remaining <= WARN_SECS
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tick      in   divided square wave, synchronous to clk
//   start     in   one-cycle pulse: load load_val (saturated to 99) and run
//   pause     in   level: freezes counting while high in RUN
//   cancel    in   one-cycle pulse: abort to IDLE, clear the count
//   load_val  in   [6:0] initial count in units
//   remaining out  [6:0] current count (registered)
//   bcd_tens  out  [3:0] tens digit of remaining
//   bcd_ones  out  [3:0] ones digit of remaining
//   running   out  high in RUN and PAUSE (registered)
//   warn      out  low-time warning
//   expired   out  one-cycle pulse when the count reaches zero (registered)
// -----------------------------------------------------------------------------
module vend_countdown #(
  parameter int TICKS_PER_UNIT = 100,
  parameter int WARN_SECS      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  input  logic [6:0] load_val,
  output logic [6:0] remaining,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       warn,
  output logic       expired
);

  // Prescaler is at least one bit wide so TICKS_PER_UNIT = 1 still elaborates.
  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

  localparam logic [PW-1:0] PRE_ZERO = PW'(0);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_UNIT - 1);

  localparam logic [6:0] MAX_LOAD = 7'd99;
  localparam logic [6:0] WARN_LIM = 7'((WARN_SECS > 99) ? 99 : WARN_SECS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Split a 0..99 binary count into {tens, ones} BCD digits.
  function automatic logic [7:0] to_bcd(input logic [6:0] bin);
    logic [3:0] tens_v;
    logic [3:0] ones_v;
    tens_v = 4'(bin / 7'd10);
    ones_v = 4'(bin - (7'(tens_v) * 7'd10));
    return {tens_v, ones_v};
  endfunction

  // Clamp an out-of-range load request to the display maximum.
  function automatic logic [6:0] sat_load(input logic [6:0] val);
    logic [6:0] res_v;
    if (val > MAX_LOAD) begin
      res_v = MAX_LOAD;
    end else begin
      res_v = val;
    end
    return res_v;
  endfunction

  state_t        state_r;
  state_t        state_nx_s;
  logic [6:0]    rem_r;
  logic [6:0]    rem_nx_s;
  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_nx_s;
  logic          tick_d_r;
  logic          tick_rise_s;
  logic          expired_r;
  logic          expired_nx_s;
  logic          running_r;
  logic          running_nx_s;
  logic [6:0]    load_sat_s;
  logic [7:0]    bcd_s;

  // tick_d resets high so a tick already high at reset release is not a rise.
  assign tick_rise_s = tick & ~tick_d_r;
  assign load_sat_s  = sat_load(load_val);

  // Tick history register for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d_r <= 1'b1;
    end else begin
      tick_d_r <= tick;
    end
  end

  // Next-state, next-count and next-prescaler decode; cancel > start > pause > tick.
  always_comb begin
    state_nx_s   = state_r;
    rem_nx_s     = rem_r;
    pre_nx_s     = pre_r;
    expired_nx_s = 1'b0;

    if (cancel) begin
      state_nx_s = ST_IDLE;
      rem_nx_s   = 7'd0;
      pre_nx_s   = PRE_ZERO;
    end else if (start) begin
      pre_nx_s = PRE_ZERO;
      if (load_sat_s == 7'd0) begin
        // Zero load expires straight away without passing through RUN.
        state_nx_s   = ST_DONE;
        rem_nx_s     = 7'd0;
        expired_nx_s = 1'b1;
      end else begin
        state_nx_s = ST_RUN;
        rem_nx_s   = load_sat_s;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_RUN: begin
          if (pause) begin
            // The rise coinciding with pause entry is dropped.
            state_nx_s = ST_PAUSE;
          end else if (tick_rise_s) begin
            if (pre_r >= PRE_MAX) begin
              pre_nx_s = PRE_ZERO;
              if (rem_r <= 7'd1) begin
                state_nx_s   = ST_DONE;
                rem_nx_s     = 7'd0;
                expired_nx_s = 1'b1;
              end else begin
                rem_nx_s = rem_r - 7'd1;
              end
            end else begin
              pre_nx_s = pre_r + PRE_ONE;
            end
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          // Resume on pause release; the rise in the release cycle is dropped.
          if (!pause) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_PAUSE;
          end
        end
        ST_DONE: begin
          state_nx_s = ST_DONE;
          rem_nx_s   = 7'd0;
        end
        default: begin
          // Illegal encoding: fall back to a safe, cleared IDLE.
          state_nx_s = ST_IDLE;
          rem_nx_s   = 7'd0;
          pre_nx_s   = PRE_ZERO;
        end
      endcase
    end
  end

  // running follows the next state so it lines up with remaining.
  always_comb begin
    running_nx_s = 1'b0;
    if ((state_nx_s == ST_RUN) || (state_nx_s == ST_PAUSE)) begin
      running_nx_s = 1'b1;
    end else begin
      running_nx_s = 1'b0;
    end
  end

  // State, count, prescaler and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rem_r     <= 7'd0;
      pre_r     <= PRE_ZERO;
      expired_r <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      rem_r     <= rem_nx_s;
      pre_r     <= pre_nx_s;
      expired_r <= expired_nx_s;
      running_r <= running_nx_s;
    end
  end

  // Low-time warning, decoded from the state and count registers.
  always_comb begin
    warn = 1'b0;
    if (((state_r == ST_RUN) || (state_r == ST_PAUSE)) &&
        (rem_r != 7'd0) && (rem_r <= WARN_LIM)) begin
      warn = 1'b1;
    end else begin
      warn = 1'b0;
    end
  end

  assign bcd_s     = to_bcd(rem_r);
  assign bcd_tens  = bcd_s[7:4];
  assign bcd_ones  = bcd_s[3:0];
  assign remaining = rem_r;
  assign running   = running_r;
  assign expired   = expired_r;

endmodule

// File: tb/tb_vend_countdown.sv
// -----------------------------------------------------------------------------
// tb_vend_countdown
//
// Directed bench for vend_countdown with TICKS_PER_UNIT=4 and WARN_SECS=5.
// Inputs change 1 time unit after the rising clk edge; outputs are sampled at
// the same point, so each step() shows the result of exactly one edge.
// -----------------------------------------------------------------------------
module tb_vend_countdown;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic       pause;
  logic       cancel;
  logic [6:0] load_val;
  logic [6:0] remaining;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       running;
  logic       warn;
  logic       expired;

  int total;
  int bad;

  localparam logic [31:0] S_IDLE  = 32'd0;
  localparam logic [31:0] S_RUN   = 32'd1;
  localparam logic [31:0] S_PAUSE = 32'd2;
  localparam logic [31:0] S_DONE  = 32'd3;

  vend_countdown #(
    .TICKS_PER_UNIT(4),
    .WARN_SECS     (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .start    (start),
    .pause    (pause),
    .cancel   (cancel),
    .load_val (load_val),
    .remaining(remaining),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .running  (running),
    .warn     (warn),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full tick period: rise seen on the first edge, low on the second.
  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    tick     = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    cancel   = 1'b0;
    load_val = 7'd0;

    // Reset state (tick held high through reset).
    repeat (2) @(posedge clk);
    #1;
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_tens",      32'(bcd_tens),  32'd0);
    check("rst_ones",      32'(bcd_ones),  32'd0);
    check("rst_running",   32'(running),   32'd0);
    check("rst_warn",      32'(warn),      32'd0);
    check("rst_expired",   32'(expired),   32'd0);
    check("rst_pre",       32'(dut.pre_r), 32'd0);

    // Release reset with tick still high: no rise may be counted.
    rst_n    = 1'b1;
    start    = 1'b1;
    load_val = 7'd5;
    step();
    start = 1'b0;
    check("hold_rem_load", 32'(remaining), 32'd5);
    check("hold_pre_load", 32'(dut.pre_r), 32'd0);
    step();
    step();
    check("hold_pre_high", 32'(dut.pre_r), 32'd0);
    check("hold_rem_high", 32'(remaining), 32'd5);
    tick = 1'b0;
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("hold_cancel_state", 32'(dut.state_r), S_IDLE);

    // Main countdown: load 3, four rises per unit.
    load_val = 7'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("main_rem_load",  32'(remaining), 32'd3);
    check("main_running",   32'(running),   32'd1);
    check("main_warn_3",    32'(warn),      32'd1);
    for (int r = 1; r <= 12; r++) begin
      tick = 1'b1;
      step();
      check($sformatf("main_rem_r%0d", r), 32'(remaining), 32'(3 - (r / 4)));
      check($sformatf("main_exp_r%0d", r), 32'(expired), (r == 12) ? 32'd1 : 32'd0);
      tick = 1'b0;
      step();
    end
    check("main_exp_gone",  32'(expired),     32'd0);
    check("main_done",      32'(dut.state_r), S_DONE);
    check("main_run_low",   32'(running),     32'd0);
    check("main_warn_zero", 32'(warn),        32'd0);

    // Saturating load and BCD digits.
    load_val = 7'd120;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("sat_rem",  32'(remaining), 32'd99);
    check("sat_tens", 32'(bcd_tens),  32'd9);
    check("sat_ones", 32'(bcd_ones),  32'd9);
    check("sat_warn", 32'(warn),      32'd0);
    cancel = 1'b1;
    step();
    cancel = 1'b0;

    // Zero load goes straight to DONE with one expiry pulse.
    load_val = 7'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("zero_state",   32'(dut.state_r), S_DONE);
    check("zero_expired", 32'(expired),     32'd1);
    check("zero_running", 32'(running),     32'd0);
    step();
    check("zero_exp_once", 32'(expired), 32'd0);

    // Pause: freeze with prescaler at 2, ignoring the rise on the entry cycle.
    load_val = 7'd2;
    start    = 1'b1;
    step();
    start = 1'b0;
    tick_pulse();
    tick_pulse();
    check("pause_pre_before", 32'(dut.pre_r), 32'd2);
    pause = 1'b1;
    tick  = 1'b1;
    step();
    tick = 1'b0;
    check("pause_state",     32'(dut.state_r), S_PAUSE);
    check("pause_pre_entry", 32'(dut.pre_r),   32'd2);
    step();
    repeat (6) tick_pulse();
    check("pause_rem_held", 32'(remaining),   32'd2);
    check("pause_pre_held", 32'(dut.pre_r),   32'd2);
    check("pause_running",  32'(running),     32'd1);
    pause = 1'b0;
    step();
    check("resume_state", 32'(dut.state_r), S_RUN);
    tick_pulse();
    check("resume_pre3", 32'(dut.pre_r), 32'd3);
    tick_pulse();
    check("resume_rem", 32'(remaining),  32'd1);
    check("resume_pre", 32'(dut.pre_r),  32'd0);

    // Cancel wins over the rise that would otherwise expire the count.
    repeat (3) tick_pulse();
    check("cancel_pre3", 32'(dut.pre_r), 32'd3);
    cancel = 1'b1;
    tick   = 1'b1;
    step();
    cancel = 1'b0;
    tick   = 1'b0;
    check("cancel_state", 32'(dut.state_r), S_IDLE);
    check("cancel_rem",   32'(remaining),   32'd0);
    check("cancel_exp",   32'(expired),     32'd0);
    step();
    check("cancel_exp_after", 32'(expired), 32'd0);

    // start and cancel together: cancel wins.
    load_val = 7'd5;
    start    = 1'b1;
    cancel   = 1'b1;
    step();
    start  = 1'b0;
    cancel = 1'b0;
    check("sc_state",   32'(dut.state_r), S_IDLE);
    check("sc_rem",     32'(remaining),   32'd0);
    check("sc_running", 32'(running),     32'd0);

    // Warning threshold with load 7, then asynchronous reset mid-count.
    load_val = 7'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("warn_at7", 32'(warn), 32'd0);
    repeat (4) tick_pulse();
    check("warn_rem6", 32'(remaining), 32'd6);
    check("warn_at6",  32'(warn),      32'd0);
    repeat (4) tick_pulse();
    check("warn_rem5",  32'(remaining), 32'd5);
    check("warn_at5",   32'(warn),      32'd1);
    check("warn_tens5", 32'(bcd_tens),  32'd0);
    check("warn_ones5", 32'(bcd_ones),  32'd5);
    tick_pulse();
    tick_pulse();
    rst_n = 1'b0;
    #2;
    check("arst_rem",     32'(remaining), 32'd0);
    check("arst_running", 32'(running),   32'd0);
    check("arst_warn",    32'(warn),      32'd0);
    check("arst_expired", 32'(expired),   32'd0);
    check("arst_pre",     32'(dut.pre_r), 32'd0);
    check("arst_ones",    32'(bcd_ones),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Restart mid-RUN with pause high in the same cycle.
    load_val = 7'd5;
    start    = 1'b1;
    step();
    start = 1'b0;
    tick_pulse();
    tick_pulse();
    check("rs_pre_before", 32'(dut.pre_r), 32'd2);
    load_val = 7'd9;
    start    = 1'b1;
    pause    = 1'b1;
    step();
    start = 1'b0;
    check("rs_rem",   32'(remaining),   32'd9);
    check("rs_pre",   32'(dut.pre_r),   32'd0);
    check("rs_state", 32'(dut.state_r), S_RUN);
    step();
    check("rs_paused", 32'(dut.state_r), S_PAUSE);
    pause = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
